// File: rtl/conv_loop1_tile_scheduler.sv
// conv_loop1_tile_scheduler: sequences one conv tile (NOF channels x NROW rows) on the Loop1 MAC datapath.
//   clk, rst_n                    clock, async active-low reset
//   start / busy / done           tile start, activity flag, 1-cycle completion pulse
//   pbuf_rd_en/row_addr/valid     pixel row-block read request and response
//   wbuf_rd_en/of_addr/valid      per-channel weight read request and response
//   pixel_ready, weight_ready     launch the datapath kernel loop
//   mac_clear                     zero the datapath accumulators
//   kernel_loop_done, acc_in      datapath loop completion and accumulators
//   out_valid/ready/data/of_idx/row_idx  result stream with backpressure
module conv_loop1_tile_scheduler #(
  parameter int KX   = 3,
  parameter int PIX  = 3,
  parameter int RES  = 8,
  parameter int NOF  = 4,
  parameter int NROW = 8,
  localparam int OW  = NOF  > 1 ? $clog2(NOF)  : 1,
  localparam int RW  = NROW > 1 ? $clog2(NROW) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pbuf_rd_en,
  output logic [RW-1:0]      pbuf_row_addr,
  input  logic               pbuf_valid,
  output logic               wbuf_rd_en,
  output logic [OW-1:0]      wbuf_of_addr,
  input  logic               wbuf_valid,
  output logic               pixel_ready,
  output logic               weight_ready,
  output logic               mac_clear,
  input  logic               kernel_loop_done,
  input  logic [PIX*RES-1:0] acc_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX*RES-1:0] out_data,
  output logic [OW-1:0]      out_of_idx,
  output logic [RW-1:0]      out_row_idx
);
  if (KX < 1 || PIX < 1 || RES < 1 || NOF < 1 || NROW < 1) begin : g_param_check
    $error("conv_loop1_tile_scheduler: parameters must be positive");
  end
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RUN, S_WAIT, S_DRAIN, S_OUT, S_CLEAR, S_FIN} state_t;
  state_t             state_q, state_d;
  logic [RW-1:0]      row_q, row_d, out_row_q, out_row_d;
  logic [OW-1:0]      of_q, of_d, out_of_q, out_of_d;
  logic               pv_q, pv_d, wv_q, wv_d, first_q, first_d;
  logic [PIX*RES-1:0] out_data_q, out_data_d;
  logic               pv_now, wv_now, of_last, row_last;
  // The pixel row is fetched once per output row and reused for every channel after the first.
  assign pv_now   = pv_q | pbuf_valid | (of_q != '0);
  assign wv_now   = wv_q | wbuf_valid;
  assign of_last  = of_q == OW'(NOF - 1);
  assign row_last = row_q == RW'(NROW - 1);
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    of_d       = of_q;
    pv_d       = pv_q;
    wv_d       = wv_q;
    first_d    = first_q;
    out_data_d = out_data_q;
    out_of_d   = out_of_q;
    out_row_d  = out_row_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        row_d   = '0;
        of_d    = '0;
        first_d = 1'b1;
      end
      S_FETCH: begin
        first_d = 1'b0;
        pv_d    = pv_now & ~wv_now;
        wv_d    = wv_now & ~pv_now;
        state_d = pv_now && wv_now ? S_RUN : S_FETCH;
      end
      S_RUN:   state_d = S_WAIT;
      S_WAIT:  state_d = kernel_loop_done ? S_DRAIN : S_WAIT;
      S_DRAIN: begin
        state_d    = S_OUT;
        out_data_d = acc_in;
        out_of_d   = of_q;
        out_row_d  = row_q;
      end
      S_OUT:   state_d = out_ready ? S_CLEAR : S_OUT;
      S_CLEAR: begin
        of_d    = of_last ? '0 : of_q + 1'b1;
        row_d   = of_last ? (row_last ? '0 : row_q + 1'b1) : row_q;
        state_d = of_last && row_last ? S_FIN : S_FETCH;
        first_d = !(of_last && row_last);
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      of_q       <= '0;
      pv_q       <= 1'b0;
      wv_q       <= 1'b0;
      first_q    <= 1'b0;
      out_data_q <= '0;
      out_of_q   <= '0;
      out_row_q  <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      of_q       <= of_d;
      pv_q       <= pv_d;
      wv_q       <= wv_d;
      first_q    <= first_d;
      out_data_q <= out_data_d;
      out_of_q   <= out_of_d;
      out_row_q  <= out_row_d;
    end
  end
  assign busy          = state_q != S_IDLE;
  assign done          = state_q == S_FIN;
  assign wbuf_rd_en    = state_q == S_FETCH && first_q;
  assign pbuf_rd_en    = wbuf_rd_en && of_q == '0;
  assign pbuf_row_addr = row_q;
  assign wbuf_of_addr  = of_q;
  assign pixel_ready   = state_q == S_RUN;
  assign weight_ready  = state_q == S_RUN;
  assign mac_clear     = state_q == S_CLEAR;
  assign out_valid     = state_q == S_OUT;
  assign out_data      = out_data_q;
  assign out_of_idx    = out_of_q;
  assign out_row_idx   = out_row_q;
endmodule
